inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/sys_defs.sv | 24 ++
 rtl/ib_compact.sv | 22 ++
 rtl/ib_drop_checker.sv | 21 ++
 rtl/inst_buffer.sv | 152 +++++++++++++++
 tb/tb_inst_buffer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_defs.sv
// Shared front-end definitions: fetch packet layout, IB index width, dispatch width.
// `IB_IDX_BITS may be predefined by the build; it defaults to 4 (16-entry buffer).
`ifndef IB_IDX_BITS
`define IB_IDX_BITS 4
`endif

package sys_defs;

  localparam int XLEN               = 32;
  localparam int GHR_BITS           = 8;
  localparam int DISPATCH_WIDTH_DEF = 3;
  localparam int IB_IDX_BITS        = `IB_IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [31:0]         inst;
    logic                is_branch;
    logic                bp_pred_taken;
    logic [XLEN-1:0]     bp_pred_target;
    logic [GHR_BITS-1:0] bp_ghr_snapshot;
  } FETCH_PACKET;

endpackage

// File: rtl/ib_compact.sv
// Fetch-lane compaction: per-lane write offset (prefix count of lower valid lanes)
// and total enqueue count. Purely combinational.
module ib_compact (
  input  logic [3:0]      i_valid,
  output logic [3:0][1:0] o_offset,
  output logic [2:0]      o_n_enq
);

  logic [2:0] w_sum;

  // Running prefix sum: each valid lane lands right after the valid lanes below it.
  always_comb begin
    w_sum    = 3'd0;
    o_offset = '0;
    for (int i = 0; i < 4; i++) begin
      o_offset[i] = w_sum[1:0];
      w_sum       = w_sum + {2'b00, i_valid[i]};
    end
    o_n_enq = w_sum;
  end

endmodule

// File: rtl/ib_drop_checker.sv
// Simulation-only monitor: warns whenever a fetch packet is dropped for lack of space.
module ib_drop_checker #(
  parameter int CW = 5
) (
  input logic          i_clock,
  input logic          i_reset,
  input logic          i_flush,
  input logic [CW-1:0] i_n_enq,
  input logic [CW-1:0] i_free
);

  // A non-empty, non-flushed packet that does not fit is discarded whole.
  always_ff @(posedge i_clock) begin
    if (!i_reset && !i_flush && (i_n_enq != '0)) begin
      drop_chk: assert (i_n_enq <= i_free)
        else $warning("ib_drop_checker: fetch packet of %0d lanes dropped with %0d slots free",
                      i_n_enq, i_free);
    end
  end

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: circular queue, 4-lane compacting enqueue,
// up to DISPATCH_WIDTH in-order dequeue. Optional counters under IB_PERF_EN.
`ifndef IB_IDX_BITS
`define IB_IDX_BITS 4
`endif

module inst_buffer
  import sys_defs::*;
#(
  parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEF,
  parameter int IB_DEPTH       = 2**`IB_IDX_BITS
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  FETCH_PACKET [3:0]                     fetch_packet,
  output logic [`IB_IDX_BITS:0]                 ib_free_slots,
  input  logic                                  flush,
  output FETCH_PACKET [DISPATCH_WIDTH-1:0]      dispatch_packet,
  output logic [DISPATCH_WIDTH-1:0]             dispatch_valid,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]   dispatch_take
`ifdef IB_PERF_EN
  ,
  output logic [31:0]                           perf_full_cycles,
  output logic [31:0]                           perf_empty_cycles
`endif
);

  localparam int IDX = `IB_IDX_BITS;
  localparam int CW  = IDX + 1;

  FETCH_PACKET     r_mem [IB_DEPTH];
  logic [IDX-1:0]  r_head;
  logic [IDX-1:0]  r_tail;
  logic [CW-1:0]   r_count;

  logic [3:0]      w_lane_valid;
  logic [3:0][1:0] w_offset;
  logic [2:0]      w_n_enq_raw;
  logic [CW-1:0]   w_n_enq;
  logic [CW-1:0]   w_free;
  logic [CW-1:0]   w_n_valid;
  logic [CW-1:0]   w_n_take;
  logic [CW-1:0]   w_n_deq;
  logic [CW-1:0]   w_count_next;
  logic            w_enq_ok;

  // Gather lane valid bits for the compactor.
  always_comb begin
    w_lane_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_lane_valid[i] = fetch_packet[i].valid;
    end
  end

  ib_compact u_compact (
    .i_valid  (w_lane_valid),
    .o_offset (w_offset),
    .o_n_enq  (w_n_enq_raw)
  );

  assign w_n_enq       = CW'(w_n_enq_raw);
  assign ib_free_slots = w_free;

  // Admission, clipped dequeue and next occupancy; the fit test uses registered count only.
  always_comb begin
    w_free    = CW'(IB_DEPTH) - r_count;
    w_n_valid = (r_count > CW'(DISPATCH_WIDTH)) ? CW'(DISPATCH_WIDTH) : r_count;
    w_n_take  = CW'(dispatch_take);
    w_enq_ok  = !flush && (w_n_enq != '0) && (w_n_enq <= w_free);
    if (flush) begin
      w_n_deq = '0;
    end else if (w_n_take > w_n_valid) begin
      w_n_deq = w_n_valid;
    end else begin
      w_n_deq = w_n_take;
    end
    w_count_next = r_count + (w_enq_ok ? w_n_enq : {CW{1'b0}}) - w_n_deq;
  end

  // Oldest entries presented straight from storage; .valid mirrors the slot valid.
  always_comb begin
    dispatch_valid  = '0;
    dispatch_packet = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      dispatch_valid[i]        = !flush && (CW'(i) < r_count);
      dispatch_packet[i]       = r_mem[r_head + IDX'(i)];
      dispatch_packet[i].valid = dispatch_valid[i];
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + IDX'(w_n_deq);
      r_tail  <= w_enq_ok ? (r_tail + IDX'(w_n_enq)) : r_tail;
      r_count <= w_count_next;
    end
  end

  // Entry storage is not reset; only admitted lanes are written.
  always_ff @(posedge clock) begin
    if (!reset && w_enq_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (fetch_packet[i].valid) begin
          r_mem[r_tail + IDX'(w_offset[i])] <= fetch_packet[i];
        end
      end
    end
  end

`ifdef IB_PERF_EN
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_empty;

  // Saturating occupancy counters; flush does not touch them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_full  <= 32'd0;
      r_perf_empty <= 32'd0;
    end else begin
      if ((r_count == CW'(IB_DEPTH)) && (r_perf_full != 32'hFFFF_FFFF)) begin
        r_perf_full <= r_perf_full + 32'd1;
      end else begin
        r_perf_full <= r_perf_full;
      end
      if ((r_count == '0) && (r_perf_empty != 32'hFFFF_FFFF)) begin
        r_perf_empty <= r_perf_empty + 32'd1;
      end else begin
        r_perf_empty <= r_perf_empty;
      end
    end
  end

  assign perf_full_cycles  = r_perf_full;
  assign perf_empty_cycles = r_perf_empty;
`endif

`ifndef SYNTHESIS
  ib_drop_checker #(.CW(CW)) u_drop_chk (
    .i_clock (clock),
    .i_reset (reset),
    .i_flush (flush),
    .i_n_enq (w_n_enq),
    .i_free  (w_free)
  );
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer (IB_DEPTH=16, DISPATCH_WIDTH=3).
module tb_inst_buffer;
  import sys_defs::*;

  localparam int DW    = 3;
  localparam int DEPTH = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 flush;
  FETCH_PACKET [3:0]    fetch_packet;
  logic [4:0]           ib_free_slots;
  FETCH_PACKET [DW-1:0] dispatch_packet;
  logic [DW-1:0]        dispatch_valid;
  logic [1:0]           dispatch_take;
`ifdef IB_PERF_EN
  logic [31:0]          perf_full_cycles;
  logic [31:0]          perf_empty_cycles;
`endif

  int checks = 0;
  int errors = 0;
  FETCH_PACKET exp_q[$];

  always #5 clock = ~clock;

  inst_buffer #(.DISPATCH_WIDTH(DW), .IB_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_packet    (fetch_packet),
    .ib_free_slots   (ib_free_slots),
    .flush           (flush),
    .dispatch_packet (dispatch_packet),
    .dispatch_valid  (dispatch_valid),
    .dispatch_take   (dispatch_take)
`ifdef IB_PERF_EN
    ,
    .perf_full_cycles  (perf_full_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  function automatic FETCH_PACKET mk_lane(input logic v, input logic [31:0] pc);
    FETCH_PACKET p;
    p.valid           = v;
    p.pc              = pc;
    p.inst            = pc ^ 32'h5A5A_0F0F;
    p.is_branch       = pc[2];
    p.bp_pred_taken   = pc[3];
    p.bp_pred_target  = pc + 32'h0000_0100;
    p.bp_ghr_snapshot = pc[11:4];
    return p;
  endfunction

  // One clock: drive, compare against the scoreboard before the edge, update the model.
  task automatic cycle(input logic [3:0] mask, input logic [31:0] pc0, input int take, input logic fl);
    int n_valid;
    int n_deq;
    int n_enq;
    int free_before;
    logic [DW-1:0] exp_valid;
    for (int i = 0; i < 4; i++) fetch_packet[i] = mk_lane(mask[i], pc0 + 32'(4 * i));
    dispatch_take = 2'(take);
    flush         = fl;
    #1;
    n_valid     = (exp_q.size() > DW) ? DW : exp_q.size();
    free_before = DEPTH - exp_q.size();
    exp_valid   = '0;
    for (int i = 0; i < DW; i++) exp_valid[i] = !fl && (i < n_valid);
    checks++;
    if (dispatch_valid !== exp_valid) begin
      errors++;
      $display("FAIL dispatch_valid: got %b expected %b", dispatch_valid, exp_valid);
    end
    checks++;
    if (ib_free_slots !== 5'(free_before)) begin
      errors++;
      $display("FAIL free_slots: got %0d expected %0d", ib_free_slots, free_before);
    end
    for (int i = 0; i < (fl ? 0 : n_valid); i++) begin
      checks++;
      if (dispatch_packet[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL slot%0d: got pc %h inst %h expected pc %h inst %h", i,
                 dispatch_packet[i].pc, dispatch_packet[i].inst, exp_q[i].pc, exp_q[i].inst);
      end
    end
    if (fl) begin
      exp_q.delete();
    end else begin
      n_deq = (take > n_valid) ? n_valid : take;
      repeat (n_deq) void'(exp_q.pop_front());
      n_enq = $countones(mask);
      if (n_enq <= free_before) begin
        for (int i = 0; i < 4; i++) if (mask[i]) exp_q.push_back(mk_lane(1'b1, pc0 + 32'(4 * i)));
      end
    end
    @(posedge clock);
    #1;
    fetch_packet  = '0;
    dispatch_take = 2'd0;
    flush         = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_packet = '0;
    dispatch_take = 2'd0;
    flush = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (ib_free_slots !== 5'd16 || dispatch_valid !== 3'b000) begin
      errors++;
      $display("FAIL reset_held: got free %0d valid %b expected 16 000", ib_free_slots, dispatch_valid);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    cycle(4'b0000, 32'h0, 0, 1'b0);
    checks++;
    if (ib_free_slots !== 5'd16) begin
      errors++;
      $display("FAIL reset_free: got %0d expected 16", ib_free_slots);
    end
    checks++;
    if (dispatch_valid !== 3'b000) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 000", dispatch_valid);
    end
  endtask

  task automatic test_compact();
    cycle(4'b1010, 32'h0, 0, 1'b0);
    checks++;
    if (dispatch_valid !== 3'b011) begin
      errors++;
      $display("FAIL compact_valid: got %b expected 011", dispatch_valid);
    end
    checks++;
    if (dispatch_packet[0].pc !== 32'h4 || dispatch_packet[1].pc !== 32'hC) begin
      errors++;
      $display("FAIL compact_pc: got %h %h expected 4 c", dispatch_packet[0].pc, dispatch_packet[1].pc);
    end
    checks++;
    if (ib_free_slots !== 5'd14) begin
      errors++;
      $display("FAIL compact_free: got %0d expected 14", ib_free_slots);
    end
    cycle(4'b0000, 32'h0, 3, 1'b0);
    checks++;
    if (ib_free_slots !== 5'd16) begin
      errors++;
      $display("FAIL clip_take_free: got %0d expected 16", ib_free_slots);
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(4'b1111, 32'h100 + 32'(16 * k), 0, 1'b0);
    checks++;
    if (ib_free_slots !== 5'd0) begin
      errors++;
      $display("FAIL full_free: got %0d expected 0", ib_free_slots);
    end
    cycle(4'b0001, 32'h900, 0, 1'b0);
    checks++;
    if (ib_free_slots !== 5'd0 || dispatch_packet[0].pc !== 32'h100) begin
      errors++;
      $display("FAIL drop: got free %0d pc %h expected 0 100", ib_free_slots, dispatch_packet[0].pc);
    end
    cycle(4'b0000, 32'h0, 3, 1'b0);
    checks++;
    if (ib_free_slots !== 5'd3) begin
      errors++;
      $display("FAIL drain_free: got %0d expected 3", ib_free_slots);
    end
    repeat (5) cycle(4'b0000, 32'h0, 3, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(4'b1111, 32'h200 + 32'(16 * k), 0, 1'b0);
    repeat (4) cycle(4'b0000, 32'h0, 3, 1'b0);
    cycle(4'b0000, 32'h0, 2, 1'b0);
    // head=14, count=2; the new packet lands after the pointer wrap
    cycle(4'b1111, 32'h300, 0, 1'b0);
    checks++;
    if (dispatch_packet[0].pc !== 32'h238 || dispatch_packet[1].pc !== 32'h23C ||
        dispatch_packet[2].pc !== 32'h300 || ib_free_slots !== 5'd10) begin
      errors++;
      $display("FAIL wrap_order: got %h %h %h free %0d expected 238 23c 300 10",
               dispatch_packet[0].pc, dispatch_packet[1].pc, dispatch_packet[2].pc, ib_free_slots);
    end
    repeat (2) cycle(4'b0000, 32'h0, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(4'b1111, 32'h400, 0, 1'b0);
    cycle(4'b0001, 32'h410, 0, 1'b0);
    cycle(4'b1111, 32'h500, 3, 1'b0);
    checks++;
    if (ib_free_slots !== 5'd10 || dispatch_packet[0].pc !== 32'h40C) begin
      errors++;
      $display("FAIL enq_deq: got free %0d pc %h expected 10 40c", ib_free_slots, dispatch_packet[0].pc);
    end
    repeat (2) cycle(4'b0000, 32'h0, 3, 1'b0);
  endtask

  task automatic test_flush();
    do_reset();
    cycle(4'b1111, 32'h600, 0, 1'b0);
    cycle(4'b1111, 32'h610, 0, 1'b0);
    for (int i = 0; i < 4; i++) fetch_packet[i] = mk_lane(1'b1, 32'h700 + 32'(4 * i));
    dispatch_take = 2'd3;
    flush = 1'b1;
    #1;
    checks++;
    if (dispatch_valid !== 3'b000) begin
      errors++;
      $display("FAIL flush_valid: got %b expected 000", dispatch_valid);
    end
    @(posedge clock);
    #1;
    fetch_packet = '0;
    dispatch_take = 2'd0;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clock);
    checks++;
    if (ib_free_slots !== 5'd16 || dispatch_valid !== 3'b000) begin
      errors++;
      $display("FAIL flush_after: got free %0d valid %b expected 16 000", ib_free_slots, dispatch_valid);
    end
    cycle(4'b0110, 32'h800, 0, 1'b0);
    cycle(4'b0000, 32'h0, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    cycle(4'b1111, 32'hA00, 0, 1'b0);
    for (int i = 0; i < 4; i++) fetch_packet[i] = mk_lane(1'b1, 32'hB00 + 32'(4 * i));
    dispatch_take = 2'd1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    fetch_packet = '0;
    dispatch_take = 2'd0;
    exp_q.delete();
    @(negedge clock);
    checks++;
    if (ib_free_slots !== 5'd16 || dispatch_valid !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: got free %0d valid %b expected 16 000", ib_free_slots, dispatch_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cycle(4'($urandom_range(0, 15)), 32'h1000 + 32'(16 * c), int'($urandom_range(0, 3)),
            ($urandom_range(0, 31) == 0));
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    fetch_packet = '0;
    dispatch_take = 2'd0;
    test_reset();
    test_compact();
    test_full_drop();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
